// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS core. It holds the datapath widths,
// the ALU opcode encodings (the same encoding the ALU decodes), the memory
// access width encodings and the EX/MEM register state encoding.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_OP   = 6;

    // ALU operation codes. ADD and ADDI trap on signed overflow; the unsigned
    // variants never do.
    localparam logic [5:0] ALU_ADD   = 6'b100000;
    localparam logic [5:0] ALU_ADDU  = 6'b100001;
    localparam logic [5:0] ALU_SUB   = 6'b100010;
    localparam logic [5:0] ALU_SUBU  = 6'b100011;
    localparam logic [5:0] ALU_AND   = 6'b100100;
    localparam logic [5:0] ALU_OR    = 6'b100101;
    localparam logic [5:0] ALU_ADDI  = 6'b001000;
    localparam logic [5:0] ALU_ADDIU = 6'b001001;

    // Memory access widths carried down to the MEM stage.
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b11;

    // The EX/MEM register either runs normally or sits drained after a HALT.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } exmem_state_t;

endpackage

// File: rtl/ex_overflow_detect.sv
// ---------------------------------------------------------------------------
// ex_overflow_detect
// Combinational signed-overflow detector for the ALU result entering EX/MEM.
// Only ADD and ADDI can overflow: both operands share a sign and the result
// has the opposite sign.
//
// Ports:
//   alu_opcode  in   NB_OP    ALU operation of the instruction in EX
//   operand1    in   NB_DATA  first ALU operand
//   operand2    in   NB_DATA  second ALU operand
//   alu_result  in   NB_DATA  ALU output
//   overflow    out  1        signed overflow of a trapping add
// ---------------------------------------------------------------------------
module ex_overflow_detect #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6
) (
    input  logic [NB_OP-1:0]   alu_opcode,
    input  logic [NB_DATA-1:0] operand1,
    input  logic [NB_DATA-1:0] operand2,
    input  logic [NB_DATA-1:0] alu_result,
    output logic               overflow
);
    import mips_pkg::*;

    logic is_trapping_add;
    logic same_sign;
    logic sign_flipped;

    always_comb begin
        is_trapping_add = (alu_opcode == NB_OP'(ALU_ADD)) || (alu_opcode == NB_OP'(ALU_ADDI));
        same_sign       = (operand1[NB_DATA-1] == operand2[NB_DATA-1]);
        sign_flipped    = (alu_result[NB_DATA-1] != operand1[NB_DATA-1]);
        overflow        = is_trapping_add && same_sign && sign_flipped;
    end

endmodule

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// EX/MEM pipeline register. Captures the ALU result, store data, destination
// register and MEM/WB control bits one cycle after EX, supports stall, flush
// and draining after a HALT, feeds forwarding info back to EX from registered
// state only, and counts retired (valid, non-flushed) captures.
//
// Optional feature macro: EX_MEM_OVERFLOW_TRAP_EN
//   When defined, a signed-overflowing ADD/ADDI is captured with its
//   register/memory writes suppressed and o_overflow set for that entry.
//   When undefined, o_overflow is tied to 0 and the opcode/operand inputs
//   are unused.
//
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_valid                      EX slot holds a real instruction
//   i_alu_result, i_store_data   datapath values from EX
//   i_write_reg                  destination register
//   i_reg_write, i_mem_read,
//   i_mem_write, i_mem_to_reg,
//   i_mem_width, i_mem_unsigned  MEM/WB control
//   i_halt                       instruction is HALT
//   i_alu_opcode, i_operand1,
//   i_operand2                   overflow detection inputs
//   i_stall, i_flush             hold contents / insert bubble
//   o_*                          registered copies of the above
//   o_fwd_en/reg/data            forwarding info back to EX
//   o_halted                     pipeline drained past EX/MEM
//   o_retired                    retired-instruction counter
//   o_overflow                   entry trapped on signed overflow
// ---------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int NB_DATA = mips_pkg::NB_DATA,
    parameter int NB_REG  = mips_pkg::NB_REG,
    parameter int NB_OP   = mips_pkg::NB_OP
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_store_data,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_mem_to_reg,
    input  logic [1:0]         i_mem_width,
    input  logic               i_mem_unsigned,
    input  logic               i_halt,
    input  logic [NB_OP-1:0]   i_alu_opcode,
    input  logic [NB_DATA-1:0] i_operand1,
    input  logic [NB_DATA-1:0] i_operand2,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_DATA-1:0] o_store_data,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic [1:0]         o_mem_width,
    output logic               o_mem_unsigned,
    output logic               o_fwd_en,
    output logic [NB_REG-1:0]  o_fwd_reg,
    output logic [NB_DATA-1:0] o_fwd_data,
    output logic               o_halted,
    output logic [31:0]        o_retired,
    output logic               o_overflow
);
    import mips_pkg::*;

    exmem_state_t state;
    logic         hold;
    logic         take;
    logic         trap;
    logic [31:0]  retired_count;

    // In RUN, flush beats stall; stall freezes everything; otherwise a valid
    // instruction is taken and anything else becomes a bubble. Once HALTED
    // the register only ever loads bubbles, so stall and flush are ignored.
    always_comb begin
        hold = (state == ST_RUN) && !i_flush && i_stall;
        take = (state == ST_RUN) && !i_flush && !i_stall && i_valid;
    end

`ifdef EX_MEM_OVERFLOW_TRAP_EN
    logic ovf_detected;
    logic overflow_q;

    ex_overflow_detect #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_overflow_detect (
        .alu_opcode (i_alu_opcode),
        .operand1   (i_operand1),
        .operand2   (i_operand2),
        .alu_result (i_alu_result),
        .overflow   (ovf_detected)
    );

    assign trap = take && ovf_detected;

    // The overflow flag belongs to the captured entry: it holds with the
    // entry under stall and clears on any other load or bubble.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overflow_q <= 1'b0;
        end else if (!hold) begin
            overflow_q <= trap;
        end
    end

    assign o_overflow = overflow_q;
`else
    logic unused_overflow_inputs;

    assign unused_overflow_inputs = ^{i_alu_opcode, i_operand1, i_operand2};
    assign trap       = 1'b0;
    assign o_overflow = 1'b0;
`endif

    // Pipeline register proper. Every field is reloaded unless held; a bubble
    // is simply "take" being low, which zeroes data and control alike. A
    // trapping add keeps its data but loses its architectural side effects.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid        <= 1'b0;
            o_alu_result   <= '0;
            o_store_data   <= '0;
            o_write_reg    <= '0;
            o_reg_write    <= 1'b0;
            o_mem_read     <= 1'b0;
            o_mem_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_mem_width    <= 2'b00;
            o_mem_unsigned <= 1'b0;
        end else if (!hold) begin
            o_valid        <= take;
            o_alu_result   <= take ? i_alu_result : '0;
            o_store_data   <= take ? i_store_data : '0;
            o_write_reg    <= take ? i_write_reg  : '0;
            o_reg_write    <= take && i_reg_write && !trap;
            o_mem_read     <= take && i_mem_read  && !trap;
            o_mem_write    <= take && i_mem_write && !trap;
            o_mem_to_reg   <= take && i_mem_to_reg;
            o_mem_width    <= take ? i_mem_width : 2'b00;
            o_mem_unsigned <= take && i_mem_unsigned;
        end
    end

    // RUN/HALTED control. A captured HALT moves to HALTED; o_halted rises on
    // the following edge, when the bubble behind the HALT has been loaded.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_RUN;
            o_halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take && i_halt) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    o_halted <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Retired-instruction counter: one per valid capture, trapped entries
    // included. Wraps naturally at 32 bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            retired_count <= '0;
        end else if (take) begin
            retired_count <= retired_count + 32'd1;
        end
    end

    assign o_retired  = retired_count;
    assign o_fwd_en   = o_valid && o_reg_write && (o_write_reg != '0);
    assign o_fwd_reg  = o_write_reg;
    assign o_fwd_data = o_alu_result;

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg
// Self-checking bench for ex_mem_reg. Random and directed EX-stage traffic is
// applied one cycle at a time and every output is compared with a reference
// model of the register's documented behaviour.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_OP   = 6;

    logic               clk;
    logic               reset;
    logic               valid;
    logic [NB_DATA-1:0] aluResult;
    logic [NB_DATA-1:0] storeData;
    logic [NB_REG-1:0]  writeReg;
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic [1:0]         memWidth;
    logic               memUnsigned;
    logic               halt;
    logic [NB_OP-1:0]   aluOpcode;
    logic [NB_DATA-1:0] operand1;
    logic [NB_DATA-1:0] operand2;
    logic               stall;
    logic               flush;

    logic               oValid;
    logic [NB_DATA-1:0] oAluResult;
    logic [NB_DATA-1:0] oStoreData;
    logic [NB_REG-1:0]  oWriteReg;
    logic               oRegWrite;
    logic               oMemRead;
    logic               oMemWrite;
    logic               oMemToReg;
    logic [1:0]         oMemWidth;
    logic               oMemUnsigned;
    logic               oFwdEn;
    logic [NB_REG-1:0]  oFwdReg;
    logic [NB_DATA-1:0] oFwdData;
    logic               oHalted;
    logic [31:0]        oRetired;
    logic               oOverflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        reset;
        logic        valid;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [1:0]  width;
        logic        uns;
        logic        halt;
        logic [5:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        stall;
        logic        flush;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [1:0]  width;
        logic        uns;
        logic        ovf;
    } entry_t;

    // Reference model state: the entry the register should hold, whether a
    // HALT has been captured, whether the drain has completed, and the count.
    entry_t      mEntry;
    logic        mHaltSeen;
    logic        mHalted;
    logic [31:0] mRetired;

    ex_mem_reg #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .NB_OP   (NB_OP)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_valid        (valid),
        .i_alu_result   (aluResult),
        .i_store_data   (storeData),
        .i_write_reg    (writeReg),
        .i_reg_write    (regWrite),
        .i_mem_read     (memRead),
        .i_mem_write    (memWrite),
        .i_mem_to_reg   (memToReg),
        .i_mem_width    (memWidth),
        .i_mem_unsigned (memUnsigned),
        .i_halt         (halt),
        .i_alu_opcode   (aluOpcode),
        .i_operand1     (operand1),
        .i_operand2     (operand2),
        .i_stall        (stall),
        .i_flush        (flush),
        .o_valid        (oValid),
        .o_alu_result   (oAluResult),
        .o_store_data   (oStoreData),
        .o_write_reg    (oWriteReg),
        .o_reg_write    (oRegWrite),
        .o_mem_read     (oMemRead),
        .o_mem_write    (oMemWrite),
        .o_mem_to_reg   (oMemToReg),
        .o_mem_width    (oMemWidth),
        .o_mem_unsigned (oMemUnsigned),
        .o_fwd_en       (oFwdEn),
        .o_fwd_reg      (oFwdReg),
        .o_fwd_data     (oFwdData),
        .o_halted       (oHalted),
        .o_retired      (oRetired),
        .o_overflow     (oOverflow)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, required finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Trap rule: signed add (ADD/ADDI) whose operands agree in sign while
    // the result does not. Meaningful only when the trap feature is built in.
    function automatic logic overflowRule(input stim_t s);
`ifdef EX_MEM_OVERFLOW_TRAP_EN
        logic isAdd;
        isAdd = (s.op == 6'b100000) || (s.op == 6'b001000);
        return isAdd && (s.op1[31] == s.op2[31]) && (s.alu[31] != s.op1[31]);
`else
        return 1'b0;
`endif
    endfunction

    // Advance the reference model by one clock edge with inputs s.
    task automatic modelStep(input stim_t s);
        logic ovf;
        if (s.reset) begin
            mEntry    = '0;
            mHaltSeen = 1'b0;
            mHalted   = 1'b0;
            mRetired  = 32'd0;
        end else if (mHaltSeen) begin
            mEntry  = '0;
            mHalted = 1'b1;
        end else if (s.flush) begin
            mEntry = '0;
        end else if (s.stall) begin
            mEntry = mEntry;
        end else if (s.valid) begin
            ovf          = overflowRule(s);
            mEntry.valid = 1'b1;
            mEntry.alu   = s.alu;
            mEntry.store = s.store;
            mEntry.wr    = s.wr;
            mEntry.rw    = s.rw && !ovf;
            mEntry.mr    = s.mr && !ovf;
            mEntry.mw    = s.mw && !ovf;
            mEntry.m2r   = s.m2r;
            mEntry.width = s.width;
            mEntry.uns   = s.uns;
            mEntry.ovf   = ovf;
            mRetired     = mRetired + 32'd1;
            if (s.halt) begin
                mHaltSeen = 1'b1;
            end
        end else begin
            mEntry = '0;
        end
    endtask

    // Compare every DUT output with the model.
    task automatic compareAll(input string tag);
        checkOutput({tag, ".valid"},    64'(oValid),       64'(mEntry.valid));
        checkOutput({tag, ".alu"},      64'(oAluResult),   64'(mEntry.alu));
        checkOutput({tag, ".store"},    64'(oStoreData),   64'(mEntry.store));
        checkOutput({tag, ".wreg"},     64'(oWriteReg),    64'(mEntry.wr));
        checkOutput({tag, ".ctrl"},
                    64'({oRegWrite, oMemRead, oMemWrite, oMemToReg, oMemWidth, oMemUnsigned}),
                    64'({mEntry.rw, mEntry.mr, mEntry.mw, mEntry.m2r, mEntry.width, mEntry.uns}));
        checkOutput({tag, ".fwd_en"},   64'(oFwdEn),       64'(mEntry.valid && mEntry.rw && (mEntry.wr != 5'd0)));
        checkOutput({tag, ".fwd_reg"},  64'(oFwdReg),      64'(mEntry.wr));
        checkOutput({tag, ".fwd_data"}, 64'(oFwdData),     64'(mEntry.alu));
        checkOutput({tag, ".halted"},   64'(oHalted),      64'(mHalted));
        checkOutput({tag, ".retired"},  64'(oRetired),     64'(mRetired));
        checkOutput({tag, ".overflow"}, 64'(oOverflow),    64'(mEntry.ovf));
    endtask

    // Drive one cycle's inputs away from the active edge, step the model,
    // then sample just after the edge and compare.
    task automatic applyStimulus(input stim_t s, input string tag);
        @(negedge clk);
        reset       = s.reset;
        valid       = s.valid;
        aluResult   = s.alu;
        storeData   = s.store;
        writeReg    = s.wr;
        regWrite    = s.rw;
        memRead     = s.mr;
        memWrite    = s.mw;
        memToReg    = s.m2r;
        memWidth    = s.width;
        memUnsigned = s.uns;
        halt        = s.halt;
        aluOpcode   = s.op;
        operand1    = s.op1;
        operand2    = s.op2;
        stall       = s.stall;
        flush       = s.flush;
        modelStep(s);
        @(posedge clk);
        #1;
        compareAll(tag);
    endtask

    // Random instruction slot with controllable probabilities (percent).
    function automatic stim_t randStim(input int pValid, input int pStall, input int pFlush, input int pHalt);
        stim_t s;
        logic [5:0] ops [5];
        ops[0] = 6'b100000;
        ops[1] = 6'b001000;
        ops[2] = 6'b100001;
        ops[3] = 6'b001001;
        ops[4] = 6'b100011;
        s       = '0;
        s.valid = ($urandom_range(0, 99) < pValid);
        s.stall = ($urandom_range(0, 99) < pStall);
        s.flush = ($urandom_range(0, 99) < pFlush);
        s.halt  = ($urandom_range(0, 99) < pHalt);
        s.store = $urandom;
        s.wr    = 5'($urandom);
        s.rw    = 1'($urandom);
        s.mr    = 1'($urandom);
        s.mw    = 1'($urandom);
        s.m2r   = 1'($urandom);
        s.width = 2'($urandom);
        s.uns   = 1'($urandom);
        s.op    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)];
        // Bias operands toward sign-boundary values so overflow really occurs.
        s.op1   = ($urandom_range(0, 1) == 1) ? (32'h7FFF_FFF0 + 32'($urandom_range(0, 31))) : $urandom;
        s.op2   = ($urandom_range(0, 1) == 1) ? (32'h0000_0000 + 32'($urandom_range(0, 31))) : $urandom;
        s.alu   = ($urandom_range(0, 3) == 0) ? $urandom : (s.op1 + s.op2);
        return s;
    endfunction

    stim_t       s;
    logic [31:0] frozenRetired;

    initial begin
        mEntry    = '0;
        mHaltSeen = 1'b0;
        mHalted   = 1'b0;
        mRetired  = 32'd0;
        reset = 1'b1; valid = 1'b0; aluResult = '0; storeData = '0; writeReg = '0;
        regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0; memToReg = 1'b0;
        memWidth = 2'b00; memUnsigned = 1'b0; halt = 1'b0; aluOpcode = '0;
        operand1 = '0; operand2 = '0; stall = 1'b0; flush = 1'b0;

        // Reset with garbage on the inputs: reset overrides everything.
        s = randStim(100, 0, 0, 100);
        s.reset = 1'b1;
        applyStimulus(s, "reset0");
        applyStimulus(s, "reset1");
        checkOutput("reset_valid", 64'(oValid), 64'd0);
        checkOutput("reset_retired", 64'(oRetired), 64'd0);

        // First valid capture.
        s = '0;
        s.valid = 1'b1; s.alu = 32'h0000_00AA; s.wr = 5'd5; s.rw = 1'b1; s.width = 2'b11;
        applyStimulus(s, "first");
        checkOutput("first_alu", 64'(oAluResult), 64'hAA);
        checkOutput("first_fwd_en", 64'(oFwdEn), 64'd1);
        checkOutput("first_fwd_reg", 64'(oFwdReg), 64'd5);
        checkOutput("first_retired", 64'(oRetired), 64'd1);

        // Writes to $zero never forward.
        s.wr = 5'd0; s.alu = 32'h1234_5678;
        applyStimulus(s, "r0");
        checkOutput("r0_fwd_en", 64'(oFwdEn), 64'd0);
        checkOutput("r0_reg_write", 64'(oRegWrite), 64'd1);

        // Stall for three cycles while the inputs keep changing.
        for (int i = 0; i < 3; i++) begin
            s = randStim(100, 100, 0, 0);
            applyStimulus(s, "stall");
        end
        checkOutput("stall_alu", 64'(oAluResult), 64'h1234_5678);
        checkOutput("stall_retired", 64'(oRetired), 64'd2);

        // Flush together with stall: the flush wins.
        s = randStim(100, 100, 100, 0);
        applyStimulus(s, "flush_stall");
        checkOutput("flush_valid", 64'(oValid), 64'd0);
        checkOutput("flush_retired", 64'(oRetired), 64'd2);

        // Random traffic without HALT.
        for (int i = 0; i < 300; i++) begin
            s = randStim(70, 20, 10, 0);
            applyStimulus(s, "rand");
        end

        // Counter wrap: park with a stall, preload the counter, then one load.
        s = randStim(0, 100, 0, 0);
        applyStimulus(s, "wrap_park");
        @(negedge clk);
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        mRetired = 32'hFFFF_FFFF;
        s = randStim(100, 0, 0, 0);
        applyStimulus(s, "wrap");
        checkOutput("wrap_retired", 64'(oRetired), 64'd0);

        // HALT capture, drain, then everything ignored until reset.
        s = randStim(100, 0, 0, 0);
        s.halt = 1'b1;
        applyStimulus(s, "halt_cap");
        checkOutput("halt_cap_valid", 64'(oValid), 64'd1);
        frozenRetired = mRetired;
        for (int i = 0; i < 12; i++) begin
            s = randStim(100, 30, 30, 30);
            applyStimulus(s, "halted");
        end
        checkOutput("halted_flag", 64'(oHalted), 64'd1);
        checkOutput("halted_retired", 64'(oRetired), 64'(frozenRetired));
        checkOutput("halted_valid", 64'(oValid), 64'd0);
        s = randStim(100, 100, 0, 100);
        s.reset = 1'b1;
        applyStimulus(s, "halt_reset");
        checkOutput("halt_reset_flag", 64'(oHalted), 64'd0);
        checkOutput("halt_reset_retired", 64'(oRetired), 64'd0);

        // Signed add overflowing: trapped only when the feature is built in.
        s = '0;
        s.valid = 1'b1; s.op = 6'b100000; s.op1 = 32'h7FFF_FFFF; s.op2 = 32'h0000_0001;
        s.alu = 32'h8000_0000; s.wr = 5'd9; s.rw = 1'b1; s.mw = 1'b1;
        applyStimulus(s, "ovf_add");
`ifdef EX_MEM_OVERFLOW_TRAP_EN
        checkOutput("ovf_add_flag", 64'(oOverflow), 64'd1);
        checkOutput("ovf_add_rw", 64'(oRegWrite), 64'd0);
`else
        checkOutput("ovf_add_flag", 64'(oOverflow), 64'd0);
        checkOutput("ovf_add_rw", 64'(oRegWrite), 64'd1);
`endif
        s.stall = 1'b1;
        applyStimulus(s, "ovf_hold");
        s.stall = 1'b0;
        s.op = 6'b100001;
        applyStimulus(s, "ovf_addu");
        checkOutput("ovf_addu_flag", 64'(oOverflow), 64'd0);
        checkOutput("ovf_addu_rw", 64'(oRegWrite), 64'd1);

        // Long random run with occasional HALTs and resets.
        for (int i = 0; i < 400; i++) begin
            s = randStim(70, 15, 10, 3);
            s.reset = ($urandom_range(0, 99) < 4);
            applyStimulus(s, "mixed");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
